// File: rtl/clock_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : clock_time_keeper
//  Purpose  : HH:MM:SS time-of-day keeper with RUN / SET_HOUR / SET_MIN
//             mode machine, driven by single-cycle click pulses.
//  Ports    : clock       - system clock, rising edge
//             rst         - synchronous active-high reset
//             click_mode  - one-cycle mode button pulse
//             click_inc   - one-cycle increment button pulse
//             hours       - 0..23, registered
//             minutes     - 0..59, registered
//             seconds     - 0..59, registered
//             mode        - 0 RUN, 1 SET_HOUR, 2 SET_MIN
//             blink       - display enable for the field being edited
//             sec_pulse   - one-cycle strobe per counted second
//  Revision : 1.0 - initial release
// ============================================================================
module clock_time_keeper #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       click_mode,
    input  logic       click_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_pulse
);

    localparam int unsigned c_PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(TICKS_PER_SEC - 1);
    localparam logic [c_PW-1:0] c_HALF = c_PW'(TICKS_PER_SEC / 2);

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_SET_HOUR = 2'd1;
    localparam logic [1:0] c_SET_MIN  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_nxt;
    logic [4:0]      r_hours,   w_hours_nxt;
    logic [5:0]      r_minutes, w_minutes_nxt;
    logic [5:0]      r_seconds, w_seconds_nxt;
    logic            r_blink,   w_blink_nxt;
    logic            r_pulse,   w_pulse_nxt;
    logic            w_tick;
    logic            w_exit_set;

    assign w_tick     = (r_presc == c_LAST);
    assign w_exit_set = (r_state == c_SET_MIN) && click_mode;

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to RUN
    always_comb begin
        w_state_nxt = c_RUN;
        case (r_state)
            c_RUN:      w_state_nxt = click_mode ? c_SET_HOUR : c_RUN;
            c_SET_HOUR: w_state_nxt = click_mode ? c_SET_MIN  : c_SET_HOUR;
            c_SET_MIN:  w_state_nxt = click_mode ? c_RUN      : c_SET_MIN;
            default:    w_state_nxt = c_RUN;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_hours_nxt   = r_hours;
        w_minutes_nxt = r_minutes;
        w_seconds_nxt = r_seconds;
        w_pulse_nxt   = 1'b0;

        // Leaving SET_MIN restarts the second so the first one is full length
        if (w_exit_set) begin
            w_presc_nxt = '0;
        end else if (w_tick) begin
            w_presc_nxt = '0;
        end else begin
            w_presc_nxt = r_presc + 1'b1;
        end

        case (r_state)
            c_RUN: begin
                // A mode click on the tick cycle freezes the pre-tick time
                if (!click_mode && w_tick) begin
                    w_pulse_nxt = 1'b1;
                    if (r_seconds == 6'd59) begin
                        w_seconds_nxt = 6'd0;
                        if (r_minutes == 6'd59) begin
                            w_minutes_nxt = 6'd0;
                            w_hours_nxt   = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
                        end else begin
                            w_minutes_nxt = r_minutes + 6'd1;
                        end
                    end else begin
                        w_seconds_nxt = r_seconds + 6'd1;
                    end
                end
            end
            c_SET_HOUR: begin
                if (!click_mode && click_inc) begin
                    w_hours_nxt = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
                end
            end
            c_SET_MIN: begin
                if (click_mode) begin
                    w_seconds_nxt = 6'd0;
                end else if (click_inc) begin
                    w_minutes_nxt = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
                end
            end
            default: begin
            end
        endcase

        // Blink follows the prescaler value that will be present after the edge
        w_blink_nxt = (w_state_nxt == c_RUN) ? 1'b1 : (w_presc_nxt < c_HALF);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_presc   <= '0;
            r_hours   <= 5'd0;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
            r_blink   <= 1'b1;
            r_pulse   <= 1'b0;
        end else begin
            r_presc   <= w_presc_nxt;
            r_hours   <= w_hours_nxt;
            r_minutes <= w_minutes_nxt;
            r_seconds <= w_seconds_nxt;
            r_blink   <= w_blink_nxt;
            r_pulse   <= w_pulse_nxt;
        end
    end

    assign hours     = r_hours;
    assign minutes   = r_minutes;
    assign seconds   = r_seconds;
    assign mode      = r_state;
    assign blink     = r_blink;
    assign sec_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_time_keeper
//  Purpose  : Self-checking bench for clock_time_keeper with TICKS_PER_SEC=4.
//             A behavioural time-keeper model pushes expected outputs into a
//             scoreboard each cycle; directed checks cover the key scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_time_keeper;

    localparam int c_T = 4;

    logic       clock;
    logic       rst;
    logic       click_mode;
    logic       click_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       sec_pulse;

    clock_time_keeper #(.TICKS_PER_SEC(c_T)) dut (
        .clock      (clock),
        .rst        (rst),
        .click_mode (click_mode),
        .click_inc  (click_inc),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .mode       (mode),
        .blink      (blink),
        .sec_pulse  (sec_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       bl;
        logic       sp;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_p = 0, m_bl = 1, m_sp = 0;

    // Bookkeeping for directed checks
    int cyc = 0;
    int last_pulse = -1;
    int pulse_cnt = 0;
    int blink_ones = 0;
    bit gap_on = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update(input logic r, input logic cm, input logic ci);
        bit tick;
        int old_mode;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_p = 0; m_bl = 1; m_sp = 0;
        end else begin
            tick     = (m_p == c_T - 1);
            old_mode = m_mode;
            m_sp     = 0;
            if (old_mode == 2 && cm) m_p = 0;
            else if (tick)           m_p = 0;
            else                     m_p = m_p + 1;
            case (old_mode)
                0: begin
                    if (cm) m_mode = 1;
                    else if (tick) begin
                        m_sp = 1;
                        m_s  = m_s + 1;
                        if (m_s == 60) begin
                            m_s = 0;
                            m_m = m_m + 1;
                            if (m_m == 60) begin
                                m_m = 0;
                                m_h = (m_h + 1) % 24;
                            end
                        end
                    end
                end
                1: begin
                    if (cm) m_mode = 2;
                    else if (ci) m_h = (m_h + 1) % 24;
                end
                2: begin
                    if (cm) begin
                        m_mode = 0;
                        m_s    = 0;
                    end else if (ci) m_m = (m_m + 1) % 60;
                end
                default: m_mode = 0;
            endcase
            m_bl = (m_mode == 0) ? 1 : ((m_p < c_T / 2) ? 1 : 0);
        end
    endtask

    // One clock cycle: drive inputs, model the edge, push, then pop and compare
    task automatic step(input logic r, input logic cm, input logic ci);
        exp_t e;
        exp_t o;
        @(negedge clock);
        rst        = r;
        click_mode = cm;
        click_inc  = ci;
        @(posedge clock);
        model_update(r, cm, ci);
        e.h  = 5'(m_h);
        e.m  = 6'(m_m);
        e.s  = 6'(m_s);
        e.md = 2'(m_mode);
        e.bl = 1'(m_bl);
        e.sp = 1'(m_sp);
        sb.push_back(e);
        #1;
        cyc++;
        o = sb.pop_front();
        chk("sb_hours",     int'(hours),     int'(o.h));
        chk("sb_minutes",   int'(minutes),   int'(o.m));
        chk("sb_seconds",   int'(seconds),   int'(o.s));
        chk("sb_mode",      int'(mode),      int'(o.md));
        chk("sb_blink",     int'(blink),     int'(o.bl));
        chk("sb_sec_pulse", int'(sec_pulse), int'(o.sp));
        if (sec_pulse) begin
            if (gap_on && last_pulse >= 0) chk("pulse_gap", cyc - last_pulse, c_T);
            last_pulse = cyc;
            pulse_cnt++;
        end
        if (blink) blink_ones++;
    endtask

    int h_keep, m_keep, s_keep;
    logic bl_hist [8];

    initial begin
        rst = 1'b1; click_mode = 1'b0; click_inc = 1'b0;

        // Reset, including clicks during reset which must be overridden
        step(1, 0, 0);
        step(1, 1, 1);
        chk("rst_hours",   int'(hours),     0);
        chk("rst_minutes", int'(minutes),   0);
        chk("rst_seconds", int'(seconds),   0);
        chk("rst_mode",    int'(mode),      0);
        chk("rst_blink",   int'(blink),     1);
        chk("rst_pulse",   int'(sec_pulse), 0);

        // Free run for one minute
        gap_on = 1'b1; last_pulse = -1; pulse_cnt = 0; blink_ones = 0;
        for (int i = 0; i < 4 * 60; i++) step(0, 0, 0);
        gap_on = 1'b0;
        chk("run_minutes",    int'(minutes), 1);
        chk("run_seconds",    int'(seconds), 0);
        chk("run_pulse_cnt",  pulse_cnt, 60);
        chk("run_blink_high", blink_ones, 240);

        // Set 23:59 and roll over midnight
        step(0, 1, 0);
        chk("set_enter_hour", int'(mode), 1);
        for (int i = 0; i < 23; i++) step(0, 0, 1);
        step(0, 1, 0);
        chk("set_enter_min", int'(mode), 2);
        for (int i = 0; i < 58; i++) step(0, 0, 1);
        chk("set_2359_h", int'(hours), 23);
        chk("set_2359_m", int'(minutes), 59);
        step(0, 1, 0);
        chk("exit_mode", int'(mode), 0);
        chk("exit_secs", int'(seconds), 0);
        for (int i = 0; i < 59 * 4; i++) step(0, 0, 0);
        chk("pre_mid_h", int'(hours), 23);
        chk("pre_mid_m", int'(minutes), 59);
        chk("pre_mid_s", int'(seconds), 59);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("mid_h",     int'(hours), 0);
        chk("mid_m",     int'(minutes), 0);
        chk("mid_s",     int'(seconds), 0);
        chk("mid_pulse", int'(sec_pulse), 1);

        // Hour edit wrap 22 -> 23 -> 0 -> 1
        step(0, 1, 0);
        for (int i = 0; i < 22; i++) step(0, 0, 1);
        chk("hedit_start", int'(hours), 22);
        m_keep = int'(minutes);
        s_keep = int'(seconds);
        step(0, 0, 1); chk("hedit_23", int'(hours), 23);
        step(0, 0, 1); chk("hedit_0",  int'(hours), 0);
        step(0, 0, 1); chk("hedit_1",  int'(hours), 1);
        pulse_cnt = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("hedit_no_pulse", pulse_cnt, 0);
        chk("hedit_minutes",  int'(minutes), m_keep);
        chk("hedit_seconds",  int'(seconds), s_keep);

        // Minute edit 59 -> 0 without carry, then exit to RUN
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 1);
        chk("medit_59", int'(minutes), 59);
        step(0, 0, 1);
        chk("medit_wrap_m", int'(minutes), 0);
        chk("medit_wrap_h", int'(hours), 5);
        step(0, 1, 0);
        chk("medit_exit_mode", int'(mode), 0);
        chk("medit_exit_secs", int'(seconds), 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0);
            chk("first_sec_pulse", int'(sec_pulse), (i == 4) ? 1 : 0);
        end

        // Simultaneous clicks: mode wins, increment dropped
        h_keep = int'(hours);
        step(0, 1, 1);
        chk("simul_run_mode",  int'(mode), 1);
        chk("simul_run_hours", int'(hours), h_keep);
        step(0, 1, 1);
        chk("simul_sh_mode",  int'(mode), 2);
        chk("simul_sh_hours", int'(hours), h_keep);

        // Blink in SET_MIN is periodic 1,1,0,0, then reset mid-edit
        blink_ones = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            bl_hist[i] = blink;
        end
        chk("blink_duty", blink_ones, 4);
        for (int i = 0; i < 4; i++) chk("blink_period", int'(bl_hist[i]), int'(bl_hist[i + 4]));
        step(1, 0, 1);
        chk("rst2_hours",   int'(hours),     0);
        chk("rst2_minutes", int'(minutes),   0);
        chk("rst2_seconds", int'(seconds),   0);
        chk("rst2_mode",    int'(mode),      0);
        chk("rst2_blink",   int'(blink),     1);
        chk("rst2_pulse",   int'(sec_pulse), 0);
        step(0, 0, 1);
        chk("post_rst_inc_ignored", int'(hours), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
